// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Data-side load/store unit sitting between execute and load extension.
// Takes one memory operation at a time, checks its alignment, runs a single
// request/acknowledge transfer on a word-addressed byte-enabled bus and
// reports the outcome with a one-cycle pulse. Load data is returned raw and
// right-justified (upper bits zero); extension happens downstream.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   exValid / exReady             operation handshake from execute
//   isStore, funct3, addr,        operation descriptor (funct3 selects size:
//   storeData                     000/100 byte, 001/101 half, else word)
//   busReq, busWe, busAddr,       bus request side, held stable until busAck
//   busWdata, busBe
//   busAck, busRdata              bus completion and read word
//   loadValid, loadData           load result pulse and held data
//   storeDone                     store completion pulse
//   misaligned                    aborted-for-alignment pulse (no bus traffic)
//   busTimeout                    request abandoned after TIMEOUT_CYCLES
//   stall                         execute must hold its operation
//
// Parameter
//   TIMEOUT_CYCLES                max REQ cycles without ack; 0 = never abort
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exValid,
    output logic        exReady,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic        busAck,
    input  logic [31:0] busRdata,
    output logic        loadValid,
    output logic [31:0] loadData,
    output logic        storeDone,
    output logic        misaligned,
    output logic        busTimeout,
    output logic        stall
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic          is_store_q, is_store_d;
    logic          size_byte_q, size_byte_d;
    logic          size_half_q, size_half_d;
    logic [1:0]    addr_lo_q, addr_lo_d;

    logic          ex_ready_q, ex_ready_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic          load_valid_q, load_valid_d;
    logic [31:0]   load_data_q, load_data_d;
    logic          store_done_q, store_done_d;
    logic          misaligned_q, misaligned_d;
    logic          bus_timeout_q, bus_timeout_d;

    // Decode of the operation currently presented by execute.
    logic          in_byte, in_half, in_aligned;
    logic [3:0]    in_be;
    logic [31:0]   in_wdata;

    always_comb begin
        in_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
        in_half = (funct3 == 3'b001) || (funct3 == 3'b101);
        if (in_byte) begin
            in_aligned = 1'b1;
            in_be      = 4'b0001 << addr[1:0];
            in_wdata   = {4{storeData[7:0]}};
        end else if (in_half) begin
            in_aligned = ~addr[0];
            in_be      = 4'b0011 << {addr[1], 1'b0};
            in_wdata   = {2{storeData[15:0]}};
        end else begin
            in_aligned = (addr[1:0] == 2'b00);
            in_be      = 4'b1111;
            in_wdata   = storeData;
        end
    end

    // Right-justify the acked word using the latched byte offset.
    logic [31:0] rdata_shifted, load_fmt;

    always_comb begin
        rdata_shifted = busRdata >> {addr_lo_q, 3'b000};
        if (size_byte_q) begin
            load_fmt = {24'd0, rdata_shifted[7:0]};
        end else if (size_half_q) begin
            load_fmt = {16'd0, rdata_shifted[15:0]};
        end else begin
            load_fmt = rdata_shifted;
        end
    end

    assign wait_cnt_inc = wait_cnt_q + 1'b1;

    // Next-state logic. All outputs are registered: the *_d values describe
    // what the outputs should show in the state being entered.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        is_store_d    = is_store_q;
        size_byte_d   = size_byte_q;
        size_half_d   = size_half_q;
        addr_lo_d     = addr_lo_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        store_done_d  = 1'b0;
        misaligned_d  = 1'b0;
        bus_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                // ex_ready_q is low for the first cycle after reset, so
                // nothing is accepted until exReady has actually been shown.
                if (exValid && ex_ready_q) begin
                    is_store_d  = isStore;
                    size_byte_d = in_byte;
                    size_half_d = in_half;
                    addr_lo_d   = addr[1:0];
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = in_wdata;
                    bus_be_d    = in_be;
                    wait_cnt_d  = '0;
                    if (in_aligned) begin
                        state_d = REQ;
                    end else begin
                        state_d      = RESP;
                        misaligned_d = 1'b1;
                        if (!isStore) begin
                            load_data_d = 32'd0;
                        end
                    end
                end
            end
            REQ: begin
                // An ack in the cycle the counter would expire takes priority.
                if (busAck) begin
                    state_d = RESP;
                    if (is_store_q) begin
                        store_done_d = 1'b1;
                    end else begin
                        load_valid_d = 1'b1;
                        load_data_d  = load_fmt;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_inc == TIMEOUT_LIM)) begin
                    state_d       = RESP;
                    bus_timeout_d = 1'b1;
                    load_data_d   = 32'd0;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ex_ready_d = (state_d == IDLE);
        bus_req_d  = (state_d == REQ);
        bus_we_d   = (state_d == REQ) && is_store_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            is_store_q    <= 1'b0;
            size_byte_q   <= 1'b0;
            size_half_q   <= 1'b0;
            addr_lo_q     <= 2'b00;
            ex_ready_q    <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            bus_be_q      <= 4'd0;
            load_valid_q  <= 1'b0;
            load_data_q   <= 32'd0;
            store_done_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            is_store_q    <= is_store_d;
            size_byte_q   <= size_byte_d;
            size_half_q   <= size_half_d;
            addr_lo_q     <= addr_lo_d;
            ex_ready_q    <= ex_ready_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            load_valid_q  <= load_valid_d;
            load_data_q   <= load_data_d;
            store_done_q  <= store_done_d;
            misaligned_q  <= misaligned_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign exReady    = ex_ready_q;
    assign busReq     = bus_req_q;
    assign busWe      = bus_we_q;
    assign busAddr    = bus_addr_q;
    assign busWdata   = bus_wdata_q;
    assign busBe      = bus_be_q;
    assign loadValid  = load_valid_q;
    assign loadData   = load_data_q;
    assign storeDone  = store_done_q;
    assign misaligned = misaligned_q;
    assign busTimeout = bus_timeout_q;
    assign stall      = (state_q != IDLE) | (exValid & ~ex_ready_q);

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed steps followed by randomized operations against load_store_unit
// (TIMEOUT_CYCLES = 4). Expected bus fields, outcome pulses and load data come
// from a byte-level model of the access rules kept in this file.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic        exValid;
    logic        exReady;
    logic        isStore;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic        busAck;
    logic [31:0] busRdata;
    logic        loadValid;
    logic [31:0] loadData;
    logic        storeDone;
    logic        misaligned;
    logic        busTimeout;
    logic        stall;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_load_data;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .exValid    (exValid),
        .exReady    (exReady),
        .isStore    (isStore),
        .funct3     (funct3),
        .addr       (addr),
        .storeData  (storeData),
        .busReq     (busReq),
        .busWe      (busWe),
        .busAddr    (busAddr),
        .busWdata   (busWdata),
        .busBe      (busBe),
        .busAck     (busAck),
        .busRdata   (busRdata),
        .loadValid  (loadValid),
        .loadData   (loadData),
        .storeDone  (storeDone),
        .misaligned (misaligned),
        .busTimeout (busTimeout),
        .stall      (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-level rules) ----------------
    function automatic int op_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [31:0] a);
        int lanes;
        lanes = ((1 << sz) - 1) << (a % 4);
        return lanes[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] sd);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input int sz, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] mask;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        return (rd >> (8 * (a % 4))) & mask;
    endfunction

    // One complete operation: present, accept, optional bus wait/ack, response.
    // w = number of REQ cycles before ack; w >= T means the bus never acks.
    task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int w, input logic [31:0] rd);
        int  sz;
        bit  al, exp_mis, exp_tmo, exp_sd, exp_lv;
        sz      = op_size(f3);
        al      = ((a % sz) == 0);
        exp_mis = !al;
        exp_tmo = al && (w >= T);
        exp_sd  = al && !exp_tmo && st;
        exp_lv  = al && !exp_tmo && !st;
        if (exp_lv) exp_load_data = model_load(sz, a, rd);
        else if (exp_tmo || (exp_mis && !st)) exp_load_data = 32'd0;

        exValid = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = sd;
        check({name, " exReady"}, 32'(exReady), 32'd1);
        check({name, " stall idle"}, 32'(stall), 32'd0);
        tick;
        exValid = 1'b0;
        if (al) begin
            check({name, " busAddr"}, busAddr, {a[31:2], 2'b00});
            check({name, " busBe"}, 32'(busBe), 32'(model_be(sz, a)));
            check({name, " busWe"}, 32'(busWe), 32'(st));
            if (st) check({name, " busWdata"}, busWdata, model_wdata(sz, sd));
            for (int c = 0; c < T; c++) begin
                check({name, " busReq held"}, 32'(busReq), 32'd1);
                check({name, " stall busy"}, 32'(stall), 32'd1);
                busAck   = (c == w);
                busRdata = (c == w) ? rd : $urandom;
                tick;
                if (c == w) break;
            end
            busAck = 1'b0;
        end
        check({name, " busReq resp"}, 32'(busReq), 32'd0);
        check({name, " misaligned"}, 32'(misaligned), 32'(exp_mis));
        check({name, " busTimeout"}, 32'(busTimeout), 32'(exp_tmo));
        check({name, " storeDone"}, 32'(storeDone), 32'(exp_sd));
        check({name, " loadValid"}, 32'(loadValid), 32'(exp_lv));
        check({name, " loadData"}, loadData, exp_load_data);
        tick;
        check({name, " pulses cleared"}, 32'({misaligned, busTimeout, storeDone, loadValid}), 32'd0);
        check({name, " exReady after"}, 32'(exReady), 32'd1);
        check({name, " loadData held"}, loadData, exp_load_data);
        $display("[TB] op %s st=%0d f3=%0d addr=%h wait=%0d loadData=%h", name, st, f3, a, w, loadData);
    endtask

    initial begin
        rst = 1'b1; exValid = 1'b0; isStore = 1'b0; funct3 = 3'd0; addr = 32'd0;
        storeData = 32'd0; busAck = 1'b0; busRdata = 32'd0;
        exp_load_data = 32'd0;

        // Reset values.
        repeat (3) tick;
        check("reset exReady", 32'(exReady), 32'd0);
        check("reset busReq", 32'(busReq), 32'd0);
        check("reset outputs", 32'({busWe, busBe, loadValid, storeDone, misaligned, busTimeout, stall}), 32'd0);
        check("reset loadData", loadData, 32'd0);
        check("reset busAddr", busAddr, 32'd0);
        rst = 1'b0;
        tick;
        check("post-reset exReady", 32'(exReady), 32'd1);
        $display("[TB] reset released");

        // Ack while idle is ignored.
        busAck = 1'b1; busRdata = 32'hDEAD_BEEF;
        tick; tick;
        busAck = 1'b0;
        check("idle ack no pulse", 32'({loadValid, storeDone, busReq}), 32'd0);
        check("idle ack loadData", loadData, 32'd0);
        $display("[TB] idle ack ignored");

        // Directed plan.
        run_op("byte_store", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'd0);
        run_op("half_load_w3", 1'b0, 3'b101, 32'h0000_2002, 32'd0, 3, 32'hBEEF_1234);
        run_op("mis_word_load", 1'b0, 3'b010, 32'h0000_3001, 32'd0, 0, 32'd0);
        run_op("timeout_load", 1'b0, 3'b010, 32'h0000_3000, 32'd0, 99, 32'd0);
        run_op("word_store_w2", 1'b1, 3'b010, 32'h0000_4008, 32'h1234_5678, 2, 32'd0);

        // Reset during REQ; the ack one cycle later must be ignored.
        exValid = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000;
        tick;
        exValid = 1'b0;
        check("rstreq busReq up", 32'(busReq), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstreq busReq down", 32'(busReq), 32'd0);
        check("rstreq no pulse", 32'({loadValid, storeDone, busTimeout, misaligned}), 32'd0);
        busAck = 1'b1; busRdata = 32'h5555_AAAA;
        tick;
        busAck = 1'b0;
        check("rstreq late ack", 32'({loadValid, storeDone, busReq}), 32'd0);
        exp_load_data = 32'd0;
        check("rstreq loadData", loadData, exp_load_data);
        $display("[TB] reset during REQ done");
        run_op("after_reset", 1'b0, 3'b000, 32'h0000_7001, 32'd0, 1, 32'h0011_2233);

        // Back-to-back: second op held on exValid, accepted only at N+3.
        exValid = 1'b1; isStore = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000; storeData = 32'h1122_3344;
        tick;                                      // accept at N
        funct3 = 3'b100; isStore = 1'b0; addr = 32'h0000_9001;
        busAck = 1'b1; busRdata = 32'd0;
        check("b2b N+1 stall", 32'(stall), 32'd1);
        check("b2b N+1 exReady", 32'(exReady), 32'd0);
        check("b2b N+1 busAddr", busAddr, 32'h0000_8000);
        tick;                                      // ack at N+1
        busAck = 1'b0;
        check("b2b N+2 storeDone", 32'(storeDone), 32'd1);
        check("b2b N+2 stall", 32'(stall), 32'd1);
        check("b2b N+2 exReady", 32'(exReady), 32'd0);
        tick;
        check("b2b N+3 busReq idle", 32'(busReq), 32'd0);
        $display("[TB] back-to-back first op done");
        run_op("b2b_second", 1'b0, 3'b100, 32'h0000_9001, 32'd0, 0, 32'hCAFE_F00D);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            logic        r_st;
            logic [2:0]  r_f3;
            logic [31:0] r_a, r_sd, r_rd;
            int          r_w;
            r_st = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_sd = $urandom;
            r_rd = $urandom;
            r_w  = $urandom_range(0, T + 1);
            run_op("rand", r_st, r_f3, r_a, r_sd, r_w, r_rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side load/store unit between the execute stage and the load-extension stage. It accepts one memory operation at a time from execute and checks alignment. It then drives a word-addressed, byte-enabled memory bus with a request/acknowledge handshake and returns right-justified raw load data. Sign/zero extension is done downstream, so this block never extends.

## Interface
- TIMEOUT_CYCLES, 255: max cycles a bus request may wait for ack before abort; 0 disables timeout.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- exValid  in  1  execute presents a memory operation.
- exReady  out  1  unit can accept an operation this cycle.
- isStore  in  1  1 = store, 0 = load.
- funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU; others are treated as W.
- addr  in  32  byte address.
- storeData  in  32  store source register.
- busReq  out  1  bus request, held until ack.
- busWe  out  1  write enable.
- busAddr  out  32  {addr[31:2], 2'b00}.
- busWdata  out  32  lane-replicated store data.
- busBe  out  4  byte enables.
- busAck  in  1  bus completes the transfer this cycle.
- busRdata  in  32  read word, valid with busAck.
- loadValid  out  1  one-cycle pulse: loadData valid.
- loadData  out  32  selected bytes right-justified, upper bits zero.
- storeDone  out  1  one-cycle pulse: store completed.
- misaligned  out  1  one-cycle pulse: access aborted, no bus traffic.
- busTimeout  out  1  one-cycle pulse: request abandoned.
- stall  out  1  (state != IDLE) | (exValid & ~exReady).

## Operation
- States: IDLE, REQ, RESP.
- IDLE
  - exReady=1.
  - On exValid, latch isStore, funct3, addr[1:0], busAddr, busWdata, busBe and the alignment result.
  - Aligned access goes to REQ; misaligned access goes to RESP with the error flag set.
- Alignment: H/HU requires addr[0]=0. W requires addr[1:0]=00. B/BU is always aligned.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << {addr[1],1'b0}.
  - W: 4'b1111.
- Store data:
  - B: {4{storeData[7:0]}}.
  - H: {2{storeData[15:0]}}.
  - W: storeData.
- REQ
  - busReq=1; busWe, busAddr, busWdata and busBe are stable.
  - On busAck, capture busRdata and go to RESP.
  - The wait counter increments each REQ cycle without ack. If it reaches TIMEOUT_CYCLES (nonzero), go to RESP with the timeout flag set.
- RESP
  - Pulse exactly one of: misaligned, busTimeout, storeDone (store), or loadValid (load). Then return to IDLE.
- Load data formatting:
  - Shift the captured word right by 8*addr[1:0].
  - Mask to 8 bits (B/BU), 16 bits (H/HU) or 32 bits (W).
  - loadData holds its value until the next load response.
  - On misaligned load or timeout, loadData = 0.
- busAck outside REQ is ignored. busRdata is sampled only on ack.

## Timing
- Reset values: exReady=0 during reset, 1 the cycle after reset deasserts. All other outputs 0. State IDLE, counter 0.
- Accept at cycle N, so busReq rises at N+1.
- Ack at cycle N+k (k≥1) gives the response pulse at N+k+1 and exReady=1 at N+k+2. Minimum occupancy is 3 cycles.
- busReq deasserts the cycle after ack; no back-to-back request from the same operation.
- Misaligned: accept at N, misaligned pulse at N+1, busReq never asserted.
- Timeout: busReq is high for exactly TIMEOUT_CYCLES cycles, then busTimeout pulses the next cycle.
- An ack in the same cycle the counter hits the limit wins: the transfer completes with no timeout.
- Reset mid-operation: the next cycle has busReq=0 and state IDLE, with no response pulse. The abandoned transfer's ack is ignored.
- exValid while not in IDLE is not accepted; execute holds the operation (stall=1).

## Test plan
- Byte store: addr=0x1003, storeData=0xA5, funct3=000, isStore=1. Required: busAddr=0x1000, busBe=1000, busWdata=0xA5A5A5A5, and storeDone one cycle after ack.
- Halfword load: addr=0x2002, funct3=101, busRdata=0xBEEF1234 with ack after 3 wait cycles. Required: loadValid with loadData=0x0000BEEF, pulsed exactly once.
- Misaligned word load: addr=0x3001, funct3=010. Required: misaligned pulse at N+1, busReq stays 0, loadData=0.
- Timeout: TIMEOUT_CYCLES=4, never ack. Required: busReq high 4 cycles, then busTimeout pulse, then exReady=1.
- Reset during REQ, then ack one cycle later. Required: no loadValid/storeDone; the next operation is accepted normally.
- Back-to-back: exValid held with two queued ops and ack after 1 cycle each. Required: the second is accepted only at N+3, stall=1 in between.
